// File: rtl/led_period_meter.sv
`timescale 1ns/1ps
// Measures the rising-to-rising interval of an asynchronous blink input in whole ms.
// Latency 3 edges from blink_in to result; result held on valid/ready, overwrite flagged by overrun.
module led_period_meter #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int W           = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_blink_in,
  input  logic         i_meas_ready,
  output logic [W-1:0] o_meas_delay,
  output logic         o_meas_valid,
  output logic         o_overflow,
  output logic         o_overrun
);

  localparam int            CYC_MS   = CLK_FREQ_HZ / 1000;
  localparam int            PW       = $clog2(CYC_MS);
  localparam logic [PW-1:0] PRE_LAST = PW'(CYC_MS - 1);
  localparam logic [W-1:0]  MS_MAX   = '1;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEAS} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_s1, r_s2, r_s3;
  logic          w_rise;
  logic [PW-1:0] r_presc;
  logic [W-1:0]  r_ms_cnt;
  logic          r_sat;
  logic          w_start;
  logic          w_load;
  logic          w_cnt_run;
  logic [W-1:0]  r_meas_delay;
  logic          r_meas_valid;
  logic          r_overflow;
  logic          r_overrun;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_blink_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise = r_s2 & ~r_s3;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!i_en) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_ARM;
        S_ARM:   if (w_rise) w_state_nxt = S_MEAS;
        S_MEAS:  w_state_nxt = S_MEAS;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_start   = i_en & w_rise & ((r_state == S_ARM) | (r_state == S_MEAS));
    w_load    = i_en & w_rise & (r_state == S_MEAS);
    w_cnt_run = i_en & (r_state == S_MEAS);
  end

  // The rise cycle is the first cycle of the new interval, so the prescaler
  // restarts at 1; a load then always sees floor(N/CYC_MS).
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_presc  <= '0;
      r_ms_cnt <= '0;
      r_sat    <= 1'b0;
    end else if (w_start) begin
      r_presc  <= PW'(1);
      r_ms_cnt <= '0;
      r_sat    <= 1'b0;
    end else if (w_cnt_run) begin
      if (r_presc == PRE_LAST) begin
        r_presc <= '0;
        if (r_ms_cnt == MS_MAX) r_sat    <= 1'b1;
        else                    r_ms_cnt <= r_ms_cnt + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end else begin
      r_presc  <= '0;
      r_ms_cnt <= '0;
      r_sat    <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_meas_delay <= '0;
      r_meas_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= w_load & r_meas_valid & ~i_meas_ready;
      if (w_load) begin
        r_meas_delay <= r_ms_cnt;
        r_overflow   <= r_sat;
        r_meas_valid <= 1'b1;
      end else if (r_meas_valid & i_meas_ready) begin
        r_meas_valid <= 1'b0;
        r_overflow   <= 1'b0;
      end
    end
  end

  assign o_meas_delay = r_meas_delay;
  assign o_meas_valid = r_meas_valid;
  assign o_overflow   = r_overflow;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_led_period_meter.sv
`timescale 1ns/1ps
// Scoreboard bench for led_period_meter at 10 cycles/ms with a 4-bit delay word.
module tb_led_period_meter;

  localparam int CLK_FREQ_HZ = 10_000;
  localparam int W           = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         blink = 1'b0;
  logic         rdy = 1'b1;
  logic [W-1:0] delay;
  logic         vld;
  logic         ovf;
  logic         ovr;

  always #5 clk = ~clk;

  led_period_meter #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .W(W)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_blink_in   (blink),
    .i_meas_ready (rdy),
    .o_meas_delay (delay),
    .o_meas_valid (vld),
    .o_overflow   (ovf),
    .o_overrun    (ovr)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         o;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   ovr_cnt = 0;
  int   n_results = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input logic o);
    exp_t e;
    e.d = W'(d);
    e.o = o;
    q.push_back(e);
  endtask

  // Rise now, next rise n cycles later.
  task automatic rise_then(input int n);
    blink = 1'b1;
    tick(n / 2);
    blink = 1'b0;
    tick(n - n / 2);
  endtask

  task automatic rise_only();
    blink = 1'b1;
    tick(4);
    blink = 1'b0;
    tick(4);
  endtask

  task automatic restart();
    en = 1'b0;
    tick(2);
    en = 1'b1;
    tick(1);
  endtask

  // Monitor: every accepted result is popped and compared.
  always @(negedge clk) begin
    if (rst) begin
      if (ovr) ovr_cnt++;
      if (vld && rdy) begin
        n_results++;
        if (q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          mon_e = q.pop_front();
          check("delay", delay, mon_e.d);
          check("overflow", ovf, mon_e.o);
        end
      end
    end
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int first;
    int width;
    int ovr0;
    int nres0;

    // Reset
    en = 1'b1;
    tick(3);
    check("rst_valid", vld, 0);
    check("rst_delay", delay, 0);
    check("rst_overflow", ovf, 0);
    check("rst_overrun", ovr, 0);
    rst = 1'b1;
    tick(2);
    check("post_rst_valid", vld, 0);
    check("post_rst_delay", delay, 0);
    check("post_rst_overrun", ovr, 0);

    // Latency: 50-cycle interval
    blink = 1'b1;
    tick(25);
    blink = 1'b0;
    tick(25);
    push(5, 1'b0);
    blink = 1'b1;
    first = -1;
    width = 0;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (vld) begin
        if (first < 0) first = i;
        width++;
      end
    end
    check("latency_edges", first, 3);
    check("valid_width", width, 1);
    blink = 1'b0;
    tick(2);
    restart();

    // Rounding
    push(5, 1'b0);
    rise_then(59);
    push(6, 1'b0);
    rise_then(60);
    push(6, 1'b0);
    rise_then(61);
    rise_only();
    restart();

    // Back-pressure
    rdy = 1'b0;
    ovr0 = ovr_cnt;
    blink = 1'b1;
    tick(15);
    blink = 1'b0;
    tick(15);
    blink = 1'b1;
    tick(5);
    check("bp_first_valid", vld, 1);
    check("bp_first_delay", delay, 3);
    check("bp_no_overrun_yet", ovr_cnt - ovr0, 0);
    tick(30);
    blink = 1'b0;
    tick(35);
    blink = 1'b1;
    tick(5);
    check("bp_second_valid", vld, 1);
    check("bp_second_delay", delay, 7);
    check("bp_overrun_pulses", ovr_cnt - ovr0, 1);
    check("bp_overrun_low", ovr, 0);
    push(7, 1'b0);
    rdy = 1'b1;
    tick(1);
    check("bp_valid_drop", vld, 0);
    blink = 1'b0;
    tick(2);
    restart();

    // Saturation
    push(15, 1'b1);
    rise_then(200);
    push(2, 1'b0);
    rise_then(20);
    rise_only();
    check("sat_overflow_cleared", ovf, 0);
    restart();

    // Enable abort
    blink = 1'b1;
    tick(10);
    blink = 1'b0;
    tick(20);
    push(3, 1'b0);
    blink = 1'b1;
    tick(10);
    blink = 1'b0;
    tick(5);
    en = 1'b0;
    tick(3);
    en = 1'b1;
    tick(2);
    nres0 = n_results;
    blink = 1'b1;
    tick(10);
    blink = 1'b0;
    tick(10);
    check("en_arm_no_result", n_results - nres0, 0);
    check("en_arm_valid", vld, 0);
    push(2, 1'b0);
    blink = 1'b1;
    tick(6);
    blink = 1'b0;
    tick(4);
    check("en_rearm_result", n_results - nres0, 1);
    restart();

    // Async reset with a pending result
    rdy = 1'b0;
    blink = 1'b1;
    tick(10);
    blink = 1'b0;
    tick(20);
    blink = 1'b1;
    tick(5);
    check("arst_pending_valid", vld, 1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", vld, 0);
    check("arst_delay", delay, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    rdy = 1'b1;
    blink = 1'b0;
    tick(3);

    // Loopback: blinker with a 4 ms tic at 10 cycles/ms
    ovr0 = ovr_cnt;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) push(4, 1'b0);
      rise_then(40);
    end
    tick(10);
    check("loop_no_overrun", ovr_cnt - ovr0, 0);
    check("scoreboard_drained", q.size(), 0);
    check("total_overruns", ovr_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
